mem_access_unit: RTL and testbench

Load/store front-end placed directly upstream of the word-wide data memory DM (ports addr, datain, wmem, dataout).
- Accepts byte/halfword/word load and store requests from the CPU datapath.
- Performs alignment checks and read-modify-write for sub-word stores.
- Drives DM and returns sign- or zero-extended load data with a one-cycle response pulse.

---
 rtl/mau_pkg.sv | 30 +++
 rtl/mau_lane_align.sv | 67 ++++++
 rtl/mem_access_unit.sv | 130 +++++++++++++
 tb/tb_mem_access_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: size encodings, FSM states
// and the request alignment rule.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } mau_state_t;

  // True when the request cannot be served: an illegal size, or an address
  // that is not naturally aligned for the access width.
  function automatic logic mau_misaligned(input logic [1:0] size,
                                          input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane steering between a DM word and a sub-word access:
// extracts/extends the addressed lane for loads and splices store data into
// the addressed lane for read-modify-write stores.
module mau_lane_align
  import mau_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] merged
);

  logic signed [7:0]  byte_lane;
  logic signed [15:0] half_lane;

  // Select the addressed byte and half from the word.
  always_comb begin
    byte_lane = '0;
    case (offset)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = '0;
    endcase
    half_lane = offset[1] ? word[31:16] : word[15:0];
  end

  // Right-justify the lane and extend it; word loads pass through untouched.
  always_comb begin
    load_val = word;
    case (size)
      SZ_BYTE: load_val = sgn ? {{24{byte_lane[7]}}, byte_lane}
                              : {24'h000000, byte_lane};
      SZ_HALF: load_val = sgn ? {{16{half_lane[15]}}, half_lane}
                              : {16'h0000, half_lane};
      default: load_val = word;
    endcase
  end

  // Overwrite only the addressed lane; the remaining lanes keep DM contents.
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = word;
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for the word-wide data memory. Accepts one request at
// a time, checks alignment, performs read-modify-write for sub-word stores
// and returns extended load data with a single-cycle response pulse.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_datain,
  output logic              dm_wmem,
  input  logic [DATA_W-1:0] dm_dataout
);

  mau_state_t state, state_next;

  logic              accept;
  logic              req_bad;
  logic [1:0]        offset_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              sgn_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] index_q;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merged;

  assign accept  = req_valid && (state == IDLE);
  assign req_bad = mau_misaligned(req_size, req_addr[1:0]);

  // Lane steering works on the live DM read of the latched index.
  mau_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .word     (dm_dataout),
    .offset   (offset_q),
    .size     (size_q),
    .sgn      (sgn_q),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  // State register; reset drops any operation in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode: errors answer directly, word stores skip the read.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)                           state_next = RESP;
          else if (req_we && req_size == SZ_WORD) state_next = WRITE;
          else                                   state_next = READ;
        end
      end
      READ:    state_next = we_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture at accept and DM read capture/merge in READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      sgn_q    <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      index_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            offset_q <= req_addr[1:0];
            size_q   <= req_size;
            we_q     <= req_we;
            sgn_q    <= req_signed;
            wdata_q  <= req_wdata;
            index_q  <= {2'b00, req_addr[ADDR_W-1:2]};
            err_q    <= req_bad;
            rdata_q  <= '0;
            if (req_we && !req_bad && req_size == SZ_WORD) word_q <= req_wdata;
          end
        end
        READ: begin
          if (we_q) word_q  <= merged;
          else      rdata_q <= load_val;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode straight from state or from registers, so no glitches.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign dm_wmem   = (state == WRITE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dm_addr   = index_q;
  assign dm_datain = word_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a behavioural DM plus a word-array reference
// model; directed scenarios followed by randomized requests.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_datain;
  logic        dm_wmem;
  logic [31:0] dm_dataout;

  logic [31:0] mem [0:15];
  logic [31:0] ref_mem [0:15];
  logic [31:0] last_rdata;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dm_addr    (dm_addr),
    .dm_datain  (dm_datain),
    .dm_wmem    (dm_wmem),
    .dm_dataout (dm_dataout)
  );

  // Behavioural data memory: combinational read, write on rising edge.
  assign dm_dataout = mem[dm_addr[3:0]];
  always @(posedge clk) if (dm_wmem) mem[dm_addr[3:0]] <= dm_datain;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_mask(input logic [1:0] sz);
    return (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // Expected load result: shift the lane down, mask, optionally sign-extend.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [31:0] a);
    logic [31:0] v;
    int width;
    v = (w >> (a[1:0] * 8)) & ref_mask(sz);
    width = (sz == 2'b00) ? 8 : 16;
    if (sz != 2'b10 && sg && v[width-1]) v = v | ~ref_mask(sz);
    return v;
  endfunction

  // Issue one request, watch it to completion and compare against the model.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold);
    logic        e;
    int          idx, sh, lat, wm, exp_lat, exp_wm;
    logic [31:0] exp_rd, exp_word;
    bit          got;
    idx = int'(a[5:2]);
    sh  = int'(a[1:0]) * 8;
    e   = ref_err(sz, a);
    exp_word = ref_mem[idx];
    exp_rd   = 32'h0;
    if (e) begin
      exp_lat = 1; exp_wm = 0;
    end else if (!we) begin
      exp_lat = 2; exp_wm = 0;
      exp_rd  = ref_load(ref_mem[idx], sz, sg, a);
    end else begin
      exp_lat  = (sz == 2'b10) ? 2 : 3;
      exp_wm   = 1;
      exp_word = (ref_mem[idx] & ~(ref_mask(sz) << sh)) | ((wd & ref_mask(sz)) << sh);
    end
    @(negedge clk);
    check("ready_idle", {31'b0, req_ready}, 32'd1);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    lat = 0; wm = 0; got = 0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (dm_wmem) wm++;
      check("busy_ready", {31'b0, req_ready}, 32'd0);
      if (rsp_valid) begin
        got = 1;
        lat = c;
        last_rdata = rsp_rdata;
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e});
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("dm_addr_hi", dm_addr >> 4, 32'd0);
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("wmem_cycles", 32'(wm), 32'(exp_wm));
    ref_mem[idx] = exp_word;
    check("dm_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    last_rdata = '0;

    // Reset state
    #12;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_datain", dm_datain, 32'd0);
    check("rst_wmem", {31'b0, dm_wmem}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then word load
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 0);
    check("word_store_mem", mem[4], 32'h1234_5678);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check("word_load", last_rdata, 32'h1234_5678);

    // Sub-word read-modify-write
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 0);
    check("byte_store_mem", mem[4], 32'h1234_AB78);

    // Load extension
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0);
    check("lb_signed", last_rdata, 32'hFFFF_FFAB);
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0);
    check("lb_unsigned", last_rdata, 32'h0000_00AB);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0);
    check("lh_hi_signed", last_rdata, 32'h0000_1234);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0);
    check("lh_lo_signed", last_rdata, 32'hFFFF_AB78);

    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF, 0);
    check("half_store_mem", mem[4], 32'hBEEF_AB78);

    // Errors
    do_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000_5555, 0);
    check("err_mem_kept", mem[4], 32'hBEEF_AB78);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);

    // Reset during WRITE of a word store
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_wmem", {31'b0, dm_wmem}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_wmem", {31'b0, dm_wmem}, 32'd0);
    check("rst_mid_rsp", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rst_no_rsp", 32'(seen), 32'd0);
    check("rst_ready_after", {31'b0, req_ready}, 32'd1);
    check("rst_mem_kept", mem[8], ref_mem[8]);

    // Back-to-back loads with req_valid held high
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1);
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1);
    req_valid = 1'b0;

    // Randomized requests
    for (int n = 0; n < 200; n++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom),
             32'($urandom_range(0, 63)), $urandom, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
